xif_result_reorder_queue: RTL
=============================

// Module: xif_result_reorder_queue
// PURPOSE
//  Synthesizable, parametrised in-order completion queue between the FPU execute stage and the
//  CORE-V-XIF commit/result interfaces. Tracks every accepted instruction by X-IF id, merges
//  commit/kill and execute-done events that arrive in any order, and retires in issue order.
//  Committed results go out on the X-IF result channel (valid/ready); killed entries drop silently.
// PARAMETERS
//  DEPTH       4   outstanding entries, power of two, >=2
//  X_ID_WIDTH  4   X-IF instruction id width
//  FLEN        32  result data width
//  RD_WIDTH    5   destination register index width
// PORTS
//  ck            in   1           clock, rising edge
//  rst           in   1           synchronous reset, active-high
//  alloc_valid   in   1           issue stage accepted an instruction
//  alloc_ready   out  1           queue can take an allocation this cycle
//  alloc_id      in   X_ID_WIDTH  id of accepted instruction
//  alloc_rd      in   RD_WIDTH    destination register
//  alloc_we      in   1           instruction writes a register file
//  commit_valid  in   1           X-IF commit strobe
//  commit_id     in   X_ID_WIDTH  id being committed/killed
//  commit_kill   in   1           1 = kill, 0 = commit
//  exec_valid    in   1           execute unit finished an instruction
//  exec_id       in   X_ID_WIDTH  id of finished instruction
//  exec_data     in   FLEN        result value
//  exec_exc      in   1           instruction raised an exception
//  result_valid  out  1           X-IF result valid
//  result_ready  in   1           X-IF result ready
//  result_id     out  X_ID_WIDTH  retired id
//  result_data   out  FLEN        retired value
//  result_rd     out  RD_WIDTH    retired destination
//  result_we     out  1           retired write enable
//  result_exc    out  1           retired exception flag
//  occupancy     out  $clog2(DEPTH)+1  live entries
// BEHAVIOUR
//  Reset (rst=1 at ck edge): all entries FREE, head=tail=0, occupancy=0; result_valid=0,
//   alloc_ready=1, result_* data outputs 0. Reset mid-operation discards all entries, no result emitted.
//  Entry state: FREE -> PENDING on alloc; flags committed, killed, done set independently by
//   commit/exec; PENDING -> FREE on retire at head. Per-entry fields: id, rd, we, data, exc.
//  alloc: accepted when alloc_valid && alloc_ready; writes tail, tail+1 mod DEPTH (wraps).
//  alloc_ready = !full && !(alloc_id matches a PENDING entry); full from registered occupancy,
//   so a retire in the same cycle does not make room until the next cycle.
//  commit: id CAM-matched against PENDING entries and against the same-cycle allocation;
//   kill sets killed, else sets committed. No match -> ignored. Second commit on same id ignored.
//  exec: CAM-matched against PENDING entries only; sets done, captures data/exc. Match on a
//   killed entry is absorbed (no data kept). No match -> ignored (assertion flags it).
//  Retire, head only, at most one per cycle:
//   head killed -> freed that cycle, no result (done not required).
//   head committed && done -> result_valid=1 combinationally from head registers; freed on
//   result_valid && result_ready. Outputs stable while result_valid && !result_ready.
//  Latency: result_valid rises the cycle after the later of commit/exec writes the head entry
//   (1 cycle min); back-to-back retires one per cycle with result_ready held high.
//  Entries behind head never retire early even if complete (strict in-order).
//  Simultaneous alloc + retire + commit + exec in one cycle all legal; occupancy += alloc - retire.
// STRUCTURE
//  pa_rvfpm: rrq_entry_t struct {pend, committed, killed, done, id, rd, we, exc, data};
//   localparam RRQ_PTR_W = $clog2(DEPTH).
//  Sub-module rrq_id_cam: DEPTH-way id compare -> one-hot match vector + hit; instantiated
//   twice (commit path, exec path) plus one for alloc duplicate check.
//  Top: entry array, head/tail pointers with wrap, occupancy counter, retire logic.
// TESTING
//  1 alloc id3 rd=7; exec id3 data=0x3F800000; commit id3 -> result_valid next cycle,
//    id=3 data=0x3F800000 rd=7; freed on ready, occupancy 0.
//  2 alloc ids 1,2; exec 2 then 1; commit 1,2 -> results retire id1 then id2, never id2 first.
//  3 alloc ids 4,5; kill 4, commit 5, exec 5 -> only id5 result; id4 dropped with no result_valid.
//  4 fill DEPTH=4 -> alloc_ready=0; retire one with result_ready=1 -> alloc_ready=1 next cycle;
//    tail wraps to 0, ids 8..15 cycle through without loss.
//  5 result_valid held with result_ready=0 for 5 cycles -> id/data/rd constant; alloc of an
//    id already pending -> alloc_ready=0 that cycle.
//  6 rst=1 with 3 entries pending and result_valid high -> next cycle result_valid=0,
//    occupancy=0, alloc_ready=1; later commit/exec of old ids produce no result.

Source files
------------

// File: rtl/xif_result_reorder_queue_pkg.sv
// Shared types and constants for the X-IF result reorder queue.
// The entry struct is sized by these constants; the top's width parameters default to them and must stay equal.
package pa_rvfpm;

  localparam int RRQ_DEPTH      = 4;
  localparam int RRQ_X_ID_WIDTH = 4;
  localparam int RRQ_FLEN       = 32;
  localparam int RRQ_RD_WIDTH   = 5;
  localparam int RRQ_PTR_W      = $clog2(RRQ_DEPTH);

  typedef struct packed {
    logic                      pend;
    logic                      committed;
    logic                      killed;
    logic                      done;
    logic [RRQ_X_ID_WIDTH-1:0] id;
    logic [RRQ_RD_WIDTH-1:0]   rd;
    logic                      we;
    logic                      exc;
    logic [RRQ_FLEN-1:0]       data;
  } rrq_entry_t;

endpackage

// File: rtl/xif_result_reorder_queue_id_cam.sv
// DEPTH-way id comparator: one-hot match against the valid (pending) entries plus a hit flag.
module rrq_id_cam
  import pa_rvfpm::*;
#(
  parameter int DEPTH      = RRQ_DEPTH,
  parameter int X_ID_WIDTH = RRQ_X_ID_WIDTH
) (
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [DEPTH-1:0][X_ID_WIDTH-1:0] i_ids,
  input  logic [X_ID_WIDTH-1:0]            i_key,
  output logic [DEPTH-1:0]                 o_match,
  output logic                             o_hit
);

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] && (i_ids[i] == i_key);
    end
  end

  assign o_hit = |o_match;

endmodule

// File: rtl/xif_result_reorder_queue.sv
// In-order completion queue: merges X-IF commit/kill and execute-done events per id,
// retires strictly from head, emits committed results on the valid/ready result channel.
module xif_result_reorder_queue
  import pa_rvfpm::*;
#(
  parameter int DEPTH      = RRQ_DEPTH,
  parameter int X_ID_WIDTH = RRQ_X_ID_WIDTH,
  parameter int FLEN       = RRQ_FLEN,
  parameter int RD_WIDTH   = RRQ_RD_WIDTH
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [X_ID_WIDTH-1:0]   alloc_id,
  input  logic [RD_WIDTH-1:0]     alloc_rd,
  input  logic                    alloc_we,
  input  logic                    commit_valid,
  input  logic [X_ID_WIDTH-1:0]   commit_id,
  input  logic                    commit_kill,
  input  logic                    exec_valid,
  input  logic [X_ID_WIDTH-1:0]   exec_id,
  input  logic [FLEN-1:0]         exec_data,
  input  logic                    exec_exc,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [X_ID_WIDTH-1:0]   result_id,
  output logic [FLEN-1:0]         result_data,
  output logic [RD_WIDTH-1:0]     result_rd,
  output logic                    result_we,
  output logic                    result_exc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  rrq_entry_t       r_ent [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0]                 w_pend;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0] w_ids;
  logic [DEPTH-1:0]                 w_commit_match;
  logic [DEPTH-1:0]                 w_exec_match;
  logic [DEPTH-1:0]                 w_alloc_match;
  logic                             w_commit_hit;
  logic                             w_exec_hit;
  logic                             w_alloc_hit;
  logic                             w_alloc_dup;
  logic                             w_full;
  logic                             w_alloc_fire;
  logic                             w_commit_new;
  rrq_entry_t                       w_head;
  logic                             w_head_kill;
  logic                             w_head_done;
  logic                             w_retire;

  always_comb begin
    w_pend = '0;
    w_ids  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend[i] = r_ent[i].pend;
      w_ids[i]  = r_ent[i].id;
    end
  end

  rrq_id_cam #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_cam_commit (
    .i_valid (w_pend),
    .i_ids   (w_ids),
    .i_key   (commit_id),
    .o_match (w_commit_match),
    .o_hit   (w_commit_hit)
  );

  rrq_id_cam #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_cam_exec (
    .i_valid (w_pend),
    .i_ids   (w_ids),
    .i_key   (exec_id),
    .o_match (w_exec_match),
    .o_hit   (w_exec_hit)
  );

  rrq_id_cam #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_cam_alloc (
    .i_valid (w_pend),
    .i_ids   (w_ids),
    .i_key   (alloc_id),
    .o_match (w_alloc_match),
    .o_hit   (w_alloc_hit)
  );

  // Full comes from the registered count, so a same-cycle retire frees a slot only next cycle.
  assign w_full       = (r_occ == OCC_W'(DEPTH));
  assign w_alloc_dup  = w_alloc_hit | (|w_alloc_match);
  assign alloc_ready  = !w_full && !w_alloc_dup;
  assign w_alloc_fire = alloc_valid && alloc_ready;
  assign w_commit_new = commit_valid && !w_commit_hit && w_alloc_fire && (commit_id == alloc_id);

  assign w_head       = r_ent[r_head];
  assign w_head_kill  = w_head.pend && w_head.killed;
  assign w_head_done  = w_head.pend && w_head.committed && !w_head.killed && w_head.done;
  assign w_retire     = w_head_kill || (w_head_done && result_ready);

  assign result_valid = w_head_done;
  assign result_id    = w_head_done ? w_head.id   : '0;
  assign result_data  = w_head_done ? w_head.data : '0;
  assign result_rd    = w_head_done ? w_head.rd   : '0;
  assign result_we    = w_head_done && w_head.we;
  assign result_exc   = w_head_done && w_head.exc;
  assign occupancy    = r_occ;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      if (w_alloc_fire) r_tail <= r_tail + PTR_W'(1);
      if (w_retire)     r_head <= r_head + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_alloc_fire) - OCC_W'(w_retire);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_retire && (r_head == PTR_W'(i))) begin
          r_ent[i] <= '0;
        end else if (w_alloc_fire && (r_tail == PTR_W'(i))) begin
          r_ent[i] <= '{pend: 1'b1, committed: w_commit_new && !commit_kill,
                        killed: w_commit_new && commit_kill, done: 1'b0,
                        id: alloc_id, rd: alloc_rd, we: alloc_we, exc: 1'b0, data: '0};
        end else if (r_ent[i].pend) begin
          // Only the first commit/kill per entry counts; later ones are ignored.
          if (commit_valid && w_commit_match[i] && !r_ent[i].committed && !r_ent[i].killed) begin
            r_ent[i].killed    <= commit_kill;
            r_ent[i].committed <= !commit_kill;
          end
          if (exec_valid && w_exec_hit && w_exec_match[i] && !r_ent[i].killed && !r_ent[i].done) begin
            r_ent[i].done <= 1'b1;
            r_ent[i].data <= exec_data;
            r_ent[i].exc  <= exec_exc;
          end
        end
      end
    end
  end

endmodule
